full_subtractor: RTL and testbench

- Registered full subtractor: computes diff = a - b - bin and borrow-out over a WIDTH-bit operand pair.
- Result available one clock after input is accepted.
- Default WIDTH=1 gives the classic 1-bit full subtractor (a, b, borrow-in -> difference, borrow-out).
- Optional borrow-chain mode lets multi-word subtraction be streamed word by word (LS word first) using the internally stored borrow.

---
 rtl/full_subtractor.sv | 52 +++++
 tb/tb_full_subtractor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit full subtractor: diff/bout = a - b - borrow-in, one cycle latency.
// Borrow-in comes from the bin port, or from the previous result when chain is set.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             chain,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    logic             vld_q;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             eb;
    logic [WIDTH:0]   sub;

    // bout_q doubles as the stored chain borrow: both reset to 0, both load on
    // every accepted op and both hold otherwise, so they can never differ.
    assign eb  = chain ? bout_q : bin;
    assign sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, eb};

    always_comb begin
        diff_d = sub[WIDTH-1:0];
        bout_d = sub[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (in_valid) begin
            vld_q  <= 1'b1;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end else begin
            vld_q  <= 1'b0;
        end
    end

    assign out_valid = vld_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench: WIDTH=1 truth table and reset, WIDTH=8 chaining, bubbles and boundaries.
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, ch1, a1, b1, bin1;
    logic       ov1, d1, bo1;
    logic       v8, ch8, bin8;
    logic [7:0] a8, b8, d8;
    logic       ov8, bo8;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .chain(ch1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(d1), .bout(bo1)
    );

    full_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .chain(ch8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(d8), .bout(bo8)
    );

    typedef struct {
        logic a, b, bin;
        logic d, bo;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       bin, chain;
        logic [7:0] d;
        logic       bo;
    } vec8_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic v, input logic ch, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
        v8 = v; ch8 = ch; a8 = a; b8 = b; bin8 = bi;
        tick();
    endtask

    task automatic chk8(input string name, input logic ov, input logic [7:0] d, input logic bo);
        chk({name, " valid"}, {63'd0, ov8}, {63'd0, ov});
        chk({name, " diff"},  {56'd0, d8},  {56'd0, d});
        chk({name, " bout"},  {63'd0, bo8}, {63'd0, bo});
    endtask

    vec1_t t1[8];
    vec8_t t8[5];

    initial begin
        t1[0] = '{0,0,0, 0,0}; t1[1] = '{0,0,1, 1,1};
        t1[2] = '{0,1,0, 1,1}; t1[3] = '{0,1,1, 0,1};
        t1[4] = '{1,0,0, 1,0}; t1[5] = '{1,0,1, 0,0};
        t1[6] = '{1,1,0, 0,0}; t1[7] = '{1,1,1, 1,1};

        t8[0] = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1};
        t8[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0};
        // stored borrow is 0 here, so chain must ignore bin=1
        t8[2] = '{8'h03, 8'h01, 1'b1, 1'b1, 8'h02, 1'b0};
        t8[3] = '{8'h80, 8'h7F, 1'b1, 1'b0, 8'h00, 1'b0};
        t8[4] = '{8'h5A, 8'hA5, 1'b0, 1'b0, 8'hB5, 1'b1};

        rst = 1'b1;
        v1 = 0; ch1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        v8 = 0; ch8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        tick(); tick();
        chk("reset valid", {63'd0, ov1}, 64'd0);
        chk("reset diff",  {63'd0, d1},  64'd0);
        chk("reset bout",  {63'd0, bo1}, 64'd0);
        chk8("reset w8", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // WIDTH=1 truth table, back to back
        for (int i = 0; i < 8; i++) begin
            v1 = 1; ch1 = 0; a1 = t1[i].a; b1 = t1[i].b; bin1 = t1[i].bin;
            tick();
            chk($sformatf("tt%0d valid", i), {63'd0, ov1}, 64'd1);
            chk($sformatf("tt%0d diff", i),  {63'd0, d1},  {63'd0, t1[i].d});
            chk($sformatf("tt%0d bout", i),  {63'd0, bo1}, {63'd0, t1[i].bo});
        end

        // reset wins over an accepted op; outputs were (1,1) before
        rst = 1; v1 = 1; a1 = 0; b1 = 1; bin1 = 1;
        tick();
        chk("rst pri valid", {63'd0, ov1}, 64'd0);
        chk("rst pri diff",  {63'd0, d1},  64'd0);
        chk("rst pri bout",  {63'd0, bo1}, 64'd0);
        rst = 0; a1 = 1; b1 = 0; bin1 = 0;
        tick();
        chk("post rst valid", {63'd0, ov1}, 64'd1);
        chk("post rst diff",  {63'd0, d1},  64'd1);
        chk("post rst bout",  {63'd0, bo1}, 64'd0);
        v1 = 0;

        // two-word 0x0100 - 0x0001
        op8(1, 0, 8'h00, 8'h01, 0); chk8("chain w0", 1, 8'hFF, 1);
        op8(1, 1, 8'h01, 8'h00, 0); chk8("chain w1", 1, 8'h00, 0);

        // bubbles between the two halves, garbage on idle inputs
        op8(1, 0, 8'h00, 8'h01, 0); chk8("bub op", 1, 8'hFF, 1);
        op8(0, 1, 'x, 'x, 'x);      chk8("bub 1", 0, 8'hFF, 1);
        op8(0, 1, 'x, 'x, 'x);      chk8("bub 2", 0, 8'hFF, 1);
        op8(1, 1, 8'h05, 8'h02, 0); chk8("bub chain", 1, 8'h02, 0);

        // mid-stream reset clears the stored borrow
        op8(1, 0, 8'h00, 8'h01, 0); chk8("mid op", 1, 8'hFF, 1);
        rst = 1;
        op8(1, 0, 8'h00, 8'h01, 1); chk8("mid rst", 0, 8'h00, 0);
        rst = 0;
        op8(1, 1, 8'h05, 8'h02, 1); chk8("mid chain", 1, 8'h03, 0);

        for (int i = 0; i < 5; i++) begin
            op8(1, t8[i].chain, t8[i].a, t8[i].b, t8[i].bin);
            chk8($sformatf("bnd%0d", i), 1, t8[i].d, t8[i].bo);
        end
        op8(0, 0, 8'h00, 8'h00, 0);
        chk8("idle", 0, 8'hB5, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
